// File: rtl/gpio_ctrl_if.sv
// Register-bus port bundle for gpio_ctrl: address, write data, byte enables, read data.
interface gpio_ctrl_if;
    logic [2:0]  i_addr;
    logic [31:0] i_din;
    logic [3:0]  i_wr_en;
    logic [31:0] o_dout;

    modport master (output i_addr, output i_din, output i_wr_en, input o_dout);
    modport slave  (input i_addr, input i_din, input i_wr_en, output o_dout);
endinterface

// File: rtl/gpio_ctrl.sv
// General-purpose I/O controller: per-pin direction, atomic set/clear,
// synchronised inputs and edge-triggered, write-1-to-clear interrupts.
module gpio_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    gpio_ctrl_if.slave      bus,
    inout  wire [WIDTH-1:0] io_gpio,
    output logic [3:0]      o_irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IRQ_W  = 4;

    localparam logic [2:0] A_MODE     = 3'd0;
    localparam logic [2:0] A_DATA_OUT = 3'd1;
    localparam logic [2:0] A_DATA_IN  = 3'd2;
    localparam logic [2:0] A_RISE_EN  = 3'd3;
    localparam logic [2:0] A_FALL_EN  = 3'd4;
    localparam logic [2:0] A_STATUS   = 3'd5;
    localparam logic [2:0] A_DATA_SET = 3'd6;
    localparam logic [2:0] A_DATA_CLR = 3'd7;

    logic [WIDTH-1:0] mode, data_out, rise_en, fall_en, status;
    logic [WIDTH-1:0] mode_nxt, data_out_nxt, rise_en_nxt, fall_en_nxt, status_nxt;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] past_q;
    logic [WIDTH-1:0] s_val, rise, fall, events;
    logic [WIDTH-1:0] wmask, wbits, read_val;
    logic [DATA_W-1:0] byte_mask;
    logic [IRQ_W-1:0] irq_nxt;
    logic             wr;

    // Expand byte enables into a bit mask over the register width
    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < 4; b++) begin
            byte_mask[8*b +: 8] = {8{bus.i_wr_en[b]}};
        end
    end

    assign wr     = |bus.i_wr_en;
    assign wmask  = byte_mask[WIDTH-1:0];
    assign wbits  = bus.i_din[WIDTH-1:0] & wmask;

    assign s_val  = sync_q[SYNC_STAGES-1];
    assign rise   = s_val & ~past_q;
    assign fall   = ~s_val & past_q;
    assign events = (rise & rise_en) | (fall & fall_en);

    // Pin drivers: output-mode pins carry DATA_OUT, others float
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign io_gpio[i] = mode[i] ? data_out[i] : 1'bz;
    end

    // Register next-state from bus writes and edge events; a new edge beats a W1C clear
    always_comb begin
        mode_nxt     = mode;
        data_out_nxt = data_out;
        rise_en_nxt  = rise_en;
        fall_en_nxt  = fall_en;
        status_nxt   = status;
        if (wr) begin
            case (bus.i_addr)
                A_MODE:     mode_nxt     = (mode & ~wmask) | wbits;
                A_DATA_OUT: data_out_nxt = (data_out & ~wmask) | wbits;
                A_RISE_EN:  rise_en_nxt  = (rise_en & ~wmask) | wbits;
                A_FALL_EN:  fall_en_nxt  = (fall_en & ~wmask) | wbits;
                A_STATUS:   status_nxt   = status & ~wbits;
                A_DATA_SET: data_out_nxt = data_out | wbits;
                A_DATA_CLR: data_out_nxt = data_out & ~wbits;
                default:    ;
            endcase
        end
        status_nxt = status_nxt | events;
    end

    // Interrupt lines: pin i feeds line i mod 4, gated by that pin's enables
    always_comb begin
        irq_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            irq_nxt[2'(i)] = irq_nxt[2'(i)] | (status_nxt[i] & (rise_en_nxt[i] | fall_en_nxt[i]));
        end
    end

    // Control and status registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode     <= '0;
            data_out <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            status   <= '0;
            o_irq    <= '0;
        end else begin
            mode     <= mode_nxt;
            data_out <= data_out_nxt;
            rise_en  <= rise_en_nxt;
            fall_en  <= fall_en_nxt;
            status   <= status_nxt;
            o_irq    <= irq_nxt;
        end
    end

    // Input synchroniser plus one-cycle-delayed copy for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            past_q <= '0;
        end else begin
            sync_q[0] <= io_gpio;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            past_q <= s_val;
        end
    end

    // Combinational read mux; SET/CLR aliases read back DATA_OUT
    always_comb begin
        read_val = '0;
        case (bus.i_addr)
            A_MODE:     read_val = mode;
            A_DATA_OUT: read_val = data_out;
            A_DATA_IN:  read_val = s_val;
            A_RISE_EN:  read_val = rise_en;
            A_FALL_EN:  read_val = fall_en;
            A_STATUS:   read_val = status;
            A_DATA_SET: read_val = data_out;
            A_DATA_CLR: read_val = data_out;
            default:    read_val = '0;
        endcase
    end

    assign bus.o_dout = DATA_W'(read_val);

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised general-purpose I/O controller on the 32-bit peripheral register bus. It provides WIDTH bidirectional pins with per-pin direction, atomic set and clear of output bits, a metastability-hardened input path, and per-pin rising- and falling-edge interrupts with write-1-to-clear status. It is the next-generation replacement for the fixed 32-pin GPIO block and keeps that block's bus interface. It adds edge interrupts and atomic bit access.

## Interface
- WIDTH, 32, number of pins (1..32); register bits at WIDTH and above read 0 and ignore writes
- SYNC_STAGES, 2, input synchroniser depth (2..4)
- i_clk  in  1  system clock; all state on rising edge
- i_rst  in  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high
- i_addr  in  3  register select
- i_din  in  32  write data
- i_wr_en  in  4  byte write enables; any set bit is a write to i_addr this cycle
- o_dout  out  32  read data for i_addr, combinational
- io_gpio  inout  WIDTH  pins
- o_irq  out  4  interrupt lines, level, active-high

## Operation
- Register map (i_addr):
  - 0 MODE: 1 = output.
  - 1 DATA_OUT.
  - 2 DATA_IN: read-only, synchronised pin value.
  - 3 RISE_EN.
  - 4 FALL_EN.
  - 5 IRQ_STATUS: write-1-to-clear.
  - 6 DATA_SET: write 1 sets DATA_OUT bits; reads return DATA_OUT.
  - 7 DATA_CLR: write 1 clears DATA_OUT bits; reads return DATA_OUT.
- Byte enables apply per byte on addresses 0, 1, 3, 4, 5, 6 and 7. Writes to address 2 are ignored.
- Pin drive: io_gpio[i] = MODE[i] ? DATA_OUT[i] : Z.
- Input path: each pin passes through a SYNC_STAGES flop chain, giving the value s[i]. A further flop holds p[i], which is s[i] delayed by one clock.
- Edge detection:
  - rise[i] = s[i] & ~p[i].
  - fall[i] = ~s[i] & p[i].
- Status update: IRQ_STATUS[i] sets on (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- Output-mode pins are still sampled, so DATA_IN reads back driven values. They can also raise interrupts.
- IRQ output: o_irq[k] = OR over pins i with i mod 4 == k of IRQ_STATUS[i] & (RISE_EN[i] | FALL_EN[i]).
  - Clearing both enables masks the line but does not clear status.
- Simultaneous events:
  - Edge set and W1C clear of the same status bit in the same cycle: set wins, and the bit stays 1.
  - A DATA_SET or DATA_CLR write sets or clears only the addressed 1-bits. All other DATA_OUT bits keep their value.
- Reset, asserted at any time including mid-write: all registers, synchroniser and p flops go to 0. io_gpio goes to Z on assertion, asynchronously. o_dout reflects the zeroed state, and o_irq = 0.

## Timing
- A register write on edge n is visible on o_dout and io_gpio after edge n.
- A pin change settled before edge n appears in DATA_IN after edge n+SYNC_STAGES-1.
  - IRQ_STATUS and o_irq assert after edge n+SYNC_STAGES.
- A W1C write on edge n drops o_irq after edge n, unless another enabled edge occurs that cycle.
- Pulses shorter than one clock may be missed; no minimum width is guaranteed below 2 clocks.
- Software must wait SYNC_STAGES+1 clocks after reset release before enabling interrupts. A pin held high out of reset otherwise produces a rising edge.

## Test plan
- Reset with i_rst pulsed mid-cycle -> io_gpio all Z, o_dout = 0 at all 8 addresses, o_irq = 0.
- MODE = 0x0000_00FF, DATA_OUT = 0xA5, then DATA_SET 0x0A, then DATA_CLR 0x81 -> pins[7:0] read 0xA5, then 0xAF, then 0x2E. Pins[31:8] stay Z. DATA_IN matches after SYNC_STAGES clocks.
- Byte-enable write with i_wr_en = 4'b0100, i_din = 0xFFFF_FFFF, addr 0 -> MODE = 0x00FF_0000.
- RISE_EN[5] = 1; drive pin 5 low→high -> IRQ_STATUS = 0x20 and o_irq = 4'b0010, SYNC_STAGES+1 clocks after the change. Falling edge on pin 5 -> no change. W1C 0x20 -> o_irq = 0.
- FALL_EN[3] = 1; W1C of bit 3 coincident with a new falling edge on pin 3 -> status bit remains 1 and o_irq[3] stays high.
- WIDTH = 12 instance: write 0xFFFF_FFFF to MODE -> reads 0x0000_0FFF. Edge on pin 11 drives o_irq[3].
